// File: rtl/ysyx_22050039_mem_pkg.sv
// Shared state encoding, master IDs and constants for the IFU/LSU data-memory arbiter.
package ysyx_22050039_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam logic MST_IF = 1'b0;
    localparam logic MST_LS = 1'b1;

    localparam logic [7:0] WMASK_FULL = 8'hFF;

    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/ysyx_22050039_arb_grant.sv
// Grant selection between IFU (master 0) and LSU (master 1).
// YSYX_22050039_ARB_RR_EN: ties alternate against the last grant; otherwise the LSU always wins.
module ysyx_22050039_arb_grant
    import ysyx_22050039_mem_pkg::*;
(
    input  logic if_valid_i,
    input  logic ls_valid_i,
    input  logic last_grant_i,
    output logic gnt_valid_c_o,
    output logic gnt_id_c_o
);

    always_comb begin
        gnt_valid_c_o = if_valid_i | ls_valid_i;
        gnt_id_c_o    = MST_IF;
`ifdef YSYX_22050039_ARB_RR_EN
        if (if_valid_i && ls_valid_i) begin
            gnt_id_c_o = ~last_grant_i;
        end else if (ls_valid_i) begin
            gnt_id_c_o = MST_LS;
        end
`else
        if (ls_valid_i) begin
            gnt_id_c_o = MST_LS;
        end
`endif
    end

`ifndef YSYX_22050039_ARB_RR_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant_i;
`endif

endmodule

// File: rtl/ysyx_22050039_mem_arbiter.sv
// Shares the data-memory port between IFU and LSU: one outstanding transaction, timeout-guarded.
// Optional round-robin tie-break via YSYX_22050039_ARB_RR_EN (default: fixed LSU priority).
module ysyx_22050039_mem_arbiter
    import ysyx_22050039_mem_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    input  logic            ls_valid,
    output logic            ls_ready,
    input  logic [XLEN-1:0] ls_addr,
    input  logic            ls_wen,
    input  logic [XLEN-1:0] ls_wdata,
    input  logic [7:0]      ls_wmask,
    output logic            ls_rvalid,
    output logic [XLEN-1:0] ls_rdata,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_wen,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wmask,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [7:0]        wmask_q, wmask_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   if_rdata_q, if_rdata_d;
    logic [XLEN-1:0]   ls_rdata_q, ls_rdata_d;
    logic              rsp_set;
    logic [XLEN-1:0]   rsp_data;
    logic              gnt_valid_c;
    logic              gnt_id_c;

    // gnt_q doubles as the last-grant register for the round-robin tie-break
    ysyx_22050039_arb_grant u_grant (
        .if_valid_i    (if_valid),
        .ls_valid_i    (ls_valid),
        .last_grant_i  (gnt_q),
        .gnt_valid_c_o (gnt_valid_c),
        .gnt_id_c_o    (gnt_id_c)
    );

    // Next-state, request latching and response capture
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        rsp_set    = 1'b0;
        rsp_data   = '0;
        if_ready   = 1'b0;
        ls_ready   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // ready is gated by rst so nothing is accepted while reset is held
                if (rst && gnt_valid_c) begin
                    gnt_d   = gnt_id_c;
                    state_d = ST_ISSUE;
                    if (gnt_id_c == MST_LS) begin
                        ls_ready = 1'b1;
                        addr_d   = ls_addr;
                        wen_d    = ls_wen;
                        wdata_d  = ls_wdata;
                        wmask_d  = ls_wmask;
                    end else begin
                        if_ready = 1'b1;
                        addr_d   = if_addr;
                        wen_d    = 1'b0;
                        wdata_d  = '0;
                        wmask_d  = WMASK_FULL;
                    end
                end
            end
            ST_ISSUE: begin
                if (mem_ready) begin
                    cnt_d = '0;
                    if (mem_rvalid) begin
                        rsp_set  = 1'b1;
                        rsp_data = mem_rdata;
                        state_d  = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    rsp_set  = 1'b1;
                    rsp_data = mem_rdata;
                    state_d  = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_set = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rsp_set) begin
            if (gnt_q == MST_LS) begin
                ls_rdata_d = rsp_data;
            end else begin
                if_rdata_d = rsp_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= MST_IF;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign mem_valid = (state_q == ST_ISSUE);
    assign mem_addr  = addr_q;
    assign mem_wen   = wen_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign if_rvalid = (state_q == ST_RESP) && (gnt_q == MST_IF);
    assign ls_rvalid = (state_q == ST_RESP) && (gnt_q == MST_LS);
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ysyx_22050039_mem_arbiter.sv
// Directed bench for ysyx_22050039_mem_arbiter: scoreboard of expected responses plus a memory responder.
module tb_ysyx_22050039_mem_arbiter;

    localparam int unsigned XLEN = 64;

    logic            clk;
    logic            rst;
    logic            if_valid, if_ready, if_rvalid;
    logic [XLEN-1:0] if_addr, if_rdata;
    logic            ls_valid, ls_ready, ls_wen, ls_rvalid;
    logic [XLEN-1:0] ls_addr, ls_wdata, ls_rdata;
    logic [7:0]      ls_wmask;
    logic            mem_valid, mem_ready, mem_wen, mem_rvalid;
    logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]      mem_wmask;
    logic            err;

    typedef struct packed {
        logic        ls;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // responder configuration (written by the main sequence only)
    int rdy_dly = 0;
    int rv_dly  = 1;
    bit no_resp = 1'b0;

    // responder-owned observation state
    int              iss_cnt, wait_cnt, valid_cycles;
    bit              prev_valid, payload_changed;
    logic [XLEN-1:0] cap_addr, cap_wdata, pend_data;
    logic            cap_wen;
    logic [7:0]      cap_wmask;

    ysyx_22050039_mem_arbiter #(.XLEN(XLEN), .TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_addr    (if_addr),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .ls_valid   (ls_valid),
        .ls_ready   (ls_ready),
        .ls_addr    (ls_addr),
        .ls_wen     (ls_wen),
        .ls_wdata   (ls_wdata),
        .ls_wmask   (ls_wmask),
        .ls_rvalid  (ls_rvalid),
        .ls_rdata   (ls_rdata),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mem_fn(input logic [63:0] a);
        return (a == 64'h8000_0000) ? 64'h0000_0413 : ((a ^ 64'hA5A5_5A5A_0000_0000) + 64'd1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic ls, input logic [63:0] d);
        exp_t e;
        e.ls   = ls;
        e.data = d;
        sb.push_back(e);
    endtask

    // Returns on the negedge following acceptance (the ISSUE cycle).
    task automatic wait_grant(input logic exp_ls, input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (if_ready || ls_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_grant_seen"}, 64'(got), 64'd1);
        if (got) chk({tag, "_grant_id"}, 64'({ls_ready, if_ready}), 64'({exp_ls, ~exp_ls}));
        @(negedge clk);
    endtask

    // cyc counts negedges after the ISSUE negedge: 0 means rvalid in the 3rd cycle after accept.
    task automatic wait_resp(input int exp_cyc, input string tag);
        bit   got;
        int   cyc;
        exp_t e;
        got = 1'b0;
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if_rvalid || ls_rvalid) begin
                got = 1'b1;
                cyc = i;
                break;
            end
        end
        chk({tag, "_rvalid_seen"}, 64'(got), 64'd1);
        if (got) begin
            chk({tag, "_sb_pending"}, 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({tag, "_rvalid_route"}, 64'({ls_rvalid, if_rvalid}), 64'({e.ls, ~e.ls}));
                chk({tag, "_rdata"}, e.ls ? ls_rdata : if_rdata, e.data);
            end
            if (exp_cyc >= 0) chk({tag, "_latency"}, 64'(cyc), 64'(exp_cyc));
            @(negedge clk);
            chk({tag, "_rvalid_pulse"}, 64'({ls_rvalid, if_rvalid}), 64'd0);
        end
    endtask

    task automatic issue_req(input logic ls, input logic [63:0] a, input logic wen,
                             input logic [63:0] wd, input logic [7:0] wm,
                             input logic [63:0] expd, input string tag);
        @(negedge clk);
        if (ls) begin
            ls_valid = 1'b1;
            ls_addr  = a;
            ls_wen   = wen;
            ls_wdata = wd;
            ls_wmask = wm;
        end else begin
            if_valid = 1'b1;
            if_addr  = a;
        end
        push(ls, expd);
        wait_grant(ls, tag);
        if_valid = 1'b0;
        ls_valid = 1'b0;
    endtask

    // Memory responder: ready after rdy_dly ISSUE cycles, rvalid rv_dly cycles later (0 = same cycle)
    initial begin
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        iss_cnt = 0; wait_cnt = 0; valid_cycles = 0;
        prev_valid = 1'b0; payload_changed = 1'b0;
        cap_addr = '0; cap_wdata = '0; pend_data = '0; cap_wen = 1'b0; cap_wmask = '0;
        forever begin
            @(negedge clk);
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            if (!rst) begin
                iss_cnt = 0; wait_cnt = 0; prev_valid = 1'b0;
            end else if (mem_valid) begin
                if (!prev_valid) begin
                    cap_addr = mem_addr; cap_wen = mem_wen; cap_wdata = mem_wdata; cap_wmask = mem_wmask;
                    valid_cycles = 0; payload_changed = 1'b0;
                end else if ({mem_addr, mem_wen, mem_wdata, mem_wmask} !== {cap_addr, cap_wen, cap_wdata, cap_wmask}) begin
                    payload_changed = 1'b1;
                end
                valid_cycles++;
                prev_valid = 1'b1;
                if (iss_cnt >= rdy_dly) begin
                    mem_ready = 1'b1;
                    iss_cnt   = 0;
                    if (!no_resp) begin
                        if (rv_dly == 0) begin
                            mem_rvalid = 1'b1;
                            mem_rdata  = mem_fn(mem_addr);
                        end else begin
                            wait_cnt  = rv_dly;
                            pend_data = mem_fn(mem_addr);
                        end
                    end
                end else begin
                    iss_cnt++;
                end
            end else begin
                prev_valid = 1'b0;
                if (wait_cnt > 0) begin
                    wait_cnt--;
                    if (wait_cnt == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = pend_data;
                    end
                end
            end
        end
    end

    initial begin
        bit rr;
        int seen;
`ifdef YSYX_22050039_ARB_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        rst = 1'b1;
        if_valid = 1'b1; if_addr = '0;
        ls_valid = 1'b1; ls_addr = 64'h8000_0040; ls_wen = 1'b0; ls_wdata = '0; ls_wmask = '0;
        #2 rst = 1'b0;
        #1;
        chk("rst_ready", 64'({if_ready, ls_ready}), 64'd0);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_rvalid", 64'({if_rvalid, ls_rvalid}), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_rdata", if_rdata | ls_rdata, 64'd0);
        chk("rst_mem_payload", mem_addr | mem_wdata | 64'({mem_wen, mem_wmask}), 64'd0);
        repeat (2) @(negedge clk);
        if_valid = 1'b0; ls_valid = 1'b0; rst = 1'b1;

        // IFU alone, one wait cycle
        rdy_dly = 0; rv_dly = 1; no_resp = 1'b0;
        issue_req(1'b0, 64'h8000_0000, 1'b0, 64'd0, 8'h00, 64'h413, "if_only");
        wait_resp(1, "if_only");
        chk("if_only_mem_addr", cap_addr, 64'h8000_0000);
        chk("if_only_mem_ctl", 64'({cap_wen, cap_wmask}), 64'h0FF);

        // Simultaneous request: LSU first, IFU on the next IDLE
        @(negedge clk);
        if_valid = 1'b1; if_addr = 64'h8000_0004;
        ls_valid = 1'b1; ls_addr = 64'h8000_0100; ls_wen = 1'b0; ls_wmask = 8'hFF;
        push(1'b1, mem_fn(64'h8000_0100));
        wait_grant(1'b1, "tie_first");
        ls_valid = 1'b0;
        wait_resp(-1, "tie_ls");
        chk("tie_ls_addr", cap_addr, 64'h8000_0100);
        push(1'b0, mem_fn(64'h8000_0004));
        wait_grant(1'b0, "tie_second");
        if_valid = 1'b0;
        wait_resp(-1, "tie_if");

        // Both held valid: alternate under round-robin, LSU-only under fixed priority
        @(negedge clk);
        if_valid = 1'b1; ls_valid = 1'b1;
        for (int g = 0; g < 4; g++) begin
            bit exp_ls;
            exp_ls = rr ? (g % 2 == 0) : 1'b1;
            push(exp_ls, mem_fn(exp_ls ? ls_addr : if_addr));
            wait_grant(exp_ls, "alt");
            if (g == 3) begin
                if_valid = 1'b0; ls_valid = 1'b0;
            end
            wait_resp(-1, "alt");
        end

        // LSU write with mem_ready delayed 3 cycles
        rdy_dly = 3; rv_dly = 1;
        issue_req(1'b1, 64'h8000_0208, 1'b1, 64'hDEAD_BEEF, 8'h0F, mem_fn(64'h8000_0208), "wr");
        wait_resp(4, "wr");
        chk("wr_valid_cycles", 64'(valid_cycles), 64'd4);
        chk("wr_payload_stable", 64'(payload_changed), 64'd0);
        chk("wr_addr", cap_addr, 64'h8000_0208);
        chk("wr_wdata", cap_wdata, 64'hDEAD_BEEF);
        chk("wr_ctl", 64'({cap_wen, cap_wmask}), 64'h10F);

        // Zero-wait memory: ready and rvalid together in ISSUE
        rdy_dly = 0; rv_dly = 0;
        issue_req(1'b0, 64'h8000_0010, 1'b0, 64'd0, 8'h00, mem_fn(64'h8000_0010), "zw");
        wait_resp(0, "zw");
        chk("err_before_timeout", 64'(err), 64'd0);

        // No response: timeout after 4 WAIT cycles with rdata 0 and sticky err
        no_resp = 1'b1;
        issue_req(1'b1, 64'h8000_0300, 1'b0, 64'd0, 8'hFF, 64'd0, "tmo");
        wait_resp(4, "tmo");
        chk("tmo_err", 64'(err), 64'd1);
        no_resp = 1'b0; rv_dly = 1;
        issue_req(1'b0, 64'h8000_0020, 1'b0, 64'd0, 8'h00, mem_fn(64'h8000_0020), "after_tmo");
        wait_resp(1, "after_tmo");
        chk("err_sticky", 64'(err), 64'd1);

        // Async reset during WAIT: immediate clear, no late rvalid, then normal operation
        rv_dly = 10;
        issue_req(1'b1, 64'h8000_0400, 1'b0, 64'd0, 8'hFF, mem_fn(64'h8000_0400), "rst_mid");
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_rvalid", 64'({if_rvalid, ls_rvalid}), 64'd0);
        chk("rst_mid_err", 64'(err), 64'd0);
        chk("rst_mid_addr", mem_addr, 64'd0);
        chk("rst_mid_if_rdata", if_rdata, 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (if_rvalid || ls_rvalid) seen++;
        end
        chk("no_rvalid_after_rst", 64'(seen), 64'd0);
        rv_dly = 1;
        issue_req(1'b0, 64'h8000_0030, 1'b0, 64'd0, 8'h00, mem_fn(64'h8000_0030), "post_rst");
        wait_resp(1, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ysyx_22050039_mem_arbiter.md
Name: ysyx_22050039_mem_arbiter

Overview:
Shares the single data-memory port between instruction fetch (IFU, master 0) and load/store unit (LSU, master 1) for the multi-cycle core. Accepts valid/ready requests from both masters, grants one, and issues it to the memory port. Holds until the response returns, then routes rdata back to the granted master. Sits between IFU/LSU and the memory-bridge block that wraps pmem_read/pmem_write.

Parameters:
XLEN, 64, address/data width
TIMEOUT, 255, max cycles waiting for mem_rvalid before error response (1..255)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset (0 = reset)
if_valid  input  1  IFU request valid
if_ready  output  1  IFU request accepted
if_addr  input  XLEN  IFU fetch address
if_rvalid  output  1  IFU response valid (1-cycle pulse)
if_rdata  output  XLEN  IFU response data
ls_valid  input  1  LSU request valid
ls_ready  output  1  LSU request accepted
ls_addr  input  XLEN  LSU address
ls_wen  input  1  LSU write enable
ls_wdata  input  XLEN  LSU write data
ls_wmask  input  8  LSU byte mask
ls_rvalid  output  1  LSU response valid (1-cycle pulse; also for writes)
ls_rdata  output  XLEN  LSU response data
mem_valid  output  1  memory request valid
mem_ready  input  1  memory accepted request
mem_addr  output  XLEN  memory address
mem_wen  output  1  memory write enable
mem_wdata  output  XLEN  memory write data
mem_wmask  output  8  memory byte mask
mem_rvalid  input  1  memory response valid
mem_rdata  input  XLEN  memory response data
err  output  1  sticky timeout flag

Behaviour:
- Reset (rst=0, async): state IDLE, all outputs 0, grant=0, timeout counter 0, err 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if ls_valid -> grant LSU; else if if_valid -> grant IFU; else stay. On grant assert that master's *_ready for exactly that cycle, latch addr/wen/wdata/wmask (IFU: wen=0, wmask=0xFF) into registers, go ISSUE. Request is accepted only on valid&ready.
- ISSUE: mem_valid=1 driven from latched registers; on mem_ready -> WAIT, counter cleared. mem_valid stays high and payload stable until mem_ready.
- WAIT: counter increments each cycle; on mem_rvalid latch mem_rdata -> RESP. If counter reaches TIMEOUT with no mem_rvalid -> latch rdata=0, set err -> RESP.
- mem_rvalid in ISSUE same cycle as mem_ready: accepted, goes directly to RESP (zero-wait memory).
- RESP: granted master's *_rvalid=1 one cycle with latched rdata; other master's rvalid 0; back to IDLE. Both rdata outputs hold last latched value otherwise.
- Minimum latency request accept -> rvalid: 3 cycles (IDLE accept, ISSUE, RESP) with mem_ready and mem_rvalid both 1 in ISSUE.
- One outstanding transaction; no new *_ready while not IDLE.
- err sticky until reset.
- Masters may drop valid without being granted; arbiter never grants a non-valid master.
- Reset mid-transaction: returns to IDLE, pending transaction discarded, no rvalid emitted.
- mem_rvalid outside ISSUE/WAIT ignored.

Optional Feature:
YSYX_22050039_ARB_RR_EN: defined -> round-robin: when both valid in IDLE, grant the master not granted last (last-grant register reset to IFU so first tie goes to LSU). Undefined -> fixed LSU priority (IFU may starve).

Decomposition:
- Shared package/include ysyx_22050039_mem_pkg: state encoding (2-bit IDLE=0, ISSUE=1, WAIT=2, RESP=3), master IDs (MST_IF=0, MST_LS=1), full wmask constant 8'hFF.
- Sub-module ysyx_22050039_arb_grant: combinational grant selection (priority or RR) from valids and last-grant.

Test Plan:
- IFU only: if_addr=0x8000_0000, mem_ready=1, mem_rvalid next cycle with 0x00000413 -> if_rvalid pulse 1 cycle with if_rdata=0x413, ls_rvalid stays 0.
- Simultaneous if_valid/ls_valid, ls_addr=0x8000_0100 -> LSU granted first (ls_ready=1, if_ready=0); IFU granted on next IDLE. With RR_EN and back-to-back requests, grants alternate LS, IF, LS, IF.
- LSU write ls_wen=1, wdata=0xDEAD_BEEF, wmask=0x0F, mem_ready delayed 3 cycles -> mem_valid held with stable payload 4 cycles; ls_rvalid pulses after mem_rvalid.
- mem_rvalid never arrives, TIMEOUT=4 -> after 4 WAIT cycles ls_rvalid=1, ls_rdata=0, err=1 and stays 1.
- Async reset asserted during WAIT -> outputs 0 immediately, no rvalid later; next request completes normally.
- mem_ready and mem_rvalid both 1 in ISSUE cycle -> rvalid 3 cycles after accept.
